// File: rtl/tff_pkg.sv
// tff_pkg: shared mode encoding for the toggle-cell counter family.
package tff_pkg;

    typedef enum logic [1:0] {
        TFF_MODE_TOGGLE = 2'b00,
        TFF_MODE_UP     = 2'b01,
        TFF_MODE_DOWN   = 2'b10,
        TFF_MODE_LOAD   = 2'b11
    } tff_mode_e;

endpackage

// File: rtl/tff_bit.sv
// tff_bit: single toggle cell with synchronous active-low reset, toggle
// enable and parallel load. Both q and qb are registered so qb never glitches
// relative to q.
module tff_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic toggle,
    input  logic load,
    input  logic d,
    output logic q,
    output logic qb
);

    logic r_q;
    logic r_qb;
    logic w_next;

    // Load wins over toggle; with neither, the cell holds.
    always_comb begin
        w_next = r_q;
        if (load) begin
            w_next = d;
        end else if (toggle) begin
            w_next = ~r_q;
        end
    end

    // State and its complement update together on every clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q  <= RST_VAL;
            r_qb <= ~RST_VAL;
        end else begin
            r_q  <= w_next;
            r_qb <= ~w_next;
        end
    end

    assign q  = r_q;
    assign qb = r_qb;

endmodule

// File: rtl/tff_counter.sv
// tff_counter: WIDTH-bit bank of toggle cells working as a masked toggle
// register or a synchronous up/down counter with parallel load.
// The counter is built from same-cycle prefix AND (up) / NOR (down) toggle
// enables; no cell is clocked by another.
// Optional build macro TFF_COUNTER_SAT_EN: UP at all-ones and DOWN at zero
// hold instead of wrapping, and tc fires on every such limit attempt.
module tff_counter
    import tff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             zero
);

    tff_mode_e        w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_up_chain;
    logic [WIDTH-1:0] w_dn_chain;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_limit;
    logic [WIDTH-1:0] w_tog;
    logic [WIDTH-1:0] w_tog_en;
    logic             w_load;
    logic [WIDTH-1:0] w_q_next;
    logic             r_tc;
    logic             r_zero;

    assign w_mode = tff_mode_e'(mode);

    // Prefix chains: bit i of w_up_chain is high when q[i-1:0] are all ones,
    // bit i of w_dn_chain when q[i-1:0] are all zeros. Bit 0 always toggles.
    always_comb begin
        w_up_chain    = '0;
        w_dn_chain    = '0;
        w_up_chain[0] = 1'b1;
        w_dn_chain[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_up_chain[i] = w_up_chain[i-1] & w_q[i-1];
            w_dn_chain[i] = w_dn_chain[i-1] & ~w_q[i-1];
        end
    end

    assign w_at_max = w_up_chain[WIDTH-1] & w_q[WIDTH-1];
    assign w_at_min = w_dn_chain[WIDTH-1] & ~w_q[WIDTH-1];
    assign w_limit  = ((w_mode == TFF_MODE_UP)   && w_at_max) ||
                      ((w_mode == TFF_MODE_DOWN) && w_at_min);

    // Per-cell toggle enables selected by mode; saturating builds suppress
    // the wrap toggle at the count limit.
    always_comb begin
        w_tog = '0;
        case (w_mode)
            TFF_MODE_TOGGLE: w_tog = t;
            TFF_MODE_UP:     w_tog = w_up_chain;
            TFF_MODE_DOWN:   w_tog = w_dn_chain;
            TFF_MODE_LOAD:   w_tog = '0;
            default:         w_tog = '0;
        endcase
`ifdef TFF_COUNTER_SAT_EN
        if (w_limit) begin
            w_tog = '0;
        end
`else
`endif
    end

    assign w_tog_en = en ? w_tog : '0;
    assign w_load   = en && (w_mode == TFF_MODE_LOAD);
    assign w_q_next = w_load ? d : (w_q ^ w_tog_en);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            tff_bit #(
                .RST_VAL (RST_VAL[gi])
            ) u_bit (
                .clk    (clk),
                .rst_n  (rst_n),
                .toggle (w_tog_en[gi]),
                .load   (w_load),
                .d      (d[gi]),
                .q      (w_q[gi]),
                .qb     (w_qb[gi])
            );
        end
    endgenerate

    // Flags registered alongside the cells so they always describe the
    // current q. tc marks a wrap (or a saturated attempt) on the last edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tc   <= 1'b0;
            r_zero <= (RST_VAL == '0);
        end else begin
            r_tc   <= en && w_limit;
            r_zero <= (w_q_next == '0);
        end
    end

    assign q    = w_q;
    assign qb   = w_qb;
    assign tc   = r_tc;
    assign zero = r_zero;

endmodule

// File: tb/tb_tff_counter.sv
// tb_tff_counter: directed scenarios plus random traffic, checked every cycle
// against an arithmetic model of the counter (WIDTH=4, RST_VAL=0).
module tb_tff_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    localparam logic [1:0] M_TOG  = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

`ifdef TFF_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         tc;
    logic         zero;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int m_q     = 0;
    bit m_tc    = 1'b0;
    bit m_valid = 1'b0;

    tff_counter #(
        .WIDTH   (W),
        .RST_VAL (4'b0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .t     (t),
        .d     (d),
        .q     (q),
        .qb    (qb),
        .tc    (tc),
        .zero  (zero)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain arithmetic on the sampled inputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_q     = 0;
            m_tc    = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_tc = 1'b0;
            if (en) begin
                case (mode)
                    M_TOG:  m_q = m_q ^ int'(t);
                    M_UP: begin
                        if (m_q == MAXV) begin
                            m_tc = 1'b1;
                            if (!SAT) m_q = 0;
                        end else begin
                            m_q = m_q + 1;
                        end
                    end
                    M_DOWN: begin
                        if (m_q == 0) begin
                            m_tc = 1'b1;
                            if (!SAT) m_q = MAXV;
                        end else begin
                            m_q = m_q - 1;
                        end
                    end
                    default: m_q = int'(d);
                endcase
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_q",    32'(q),    32'(m_q));
            chk("cyc_qb",   32'(qb),   32'(MAXV - m_q));
            chk("cyc_tc",   32'(tc),   32'(m_tc));
            chk("cyc_zero", 32'(zero), 32'(m_q == 0));
        end
    end

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] tv, input logic [W-1:0] dv);
        rst_n = r;
        en    = e;
        mode  = m;
        t     = tv;
        d     = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = M_UP;
        t     = '0;
        d     = '0;

        // reset held two clocks with en=1, mode=UP
        step(1'b0, 1'b1, M_UP, 4'h0, 4'h0);
        step(1'b0, 1'b1, M_UP, 4'h0, 4'h0);
        chk("rst_q",    32'(q),    32'h0);
        chk("rst_qb",   32'(qb),   32'hF);
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_tc",   32'(tc),   32'h0);
        chk("rst_model_q", 32'(m_q), 32'h0);
        step(1'b1, 1'b1, M_UP, 4'h0, 4'h0);
        chk("rel_q", 32'(q), 32'h1);

        // up wrap over 16 clocks from zero
        step(1'b0, 1'b1, M_UP, 4'h0, 4'h0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, M_UP, 4'h0, 4'h0);
            if (!SAT || i < 16) begin
                chk("up_q",  32'(q),  32'(i % 16));
                chk("up_tc", 32'(tc), 32'(i == 16));
            end
        end
        if (!SAT) begin
            chk("wrap_zero", 32'(zero), 32'h1);
            chk("wrap_model_tc", 32'(m_tc), 32'h1);
        end

        // down wrap then hold with en low
        step(1'b1, 1'b1, M_LOAD, 4'h0, 4'h1);
        chk("load1_q", 32'(q), 32'h1);
        step(1'b1, 1'b1, M_DOWN, 4'h0, 4'h0);
        chk("dn1_q",  32'(q),  32'h0);
        chk("dn1_tc", 32'(tc), 32'h0);
        step(1'b1, 1'b1, M_DOWN, 4'h0, 4'h0);
        chk("dn2_q",  32'(q),  SAT ? 32'h0 : 32'hF);
        chk("dn2_tc", 32'(tc), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, M_DOWN, 4'h0, 4'h0);
            chk("hold_q",  32'(q),  SAT ? 32'h0 : 32'hF);
            chk("hold_tc", 32'(tc), 32'h0);
        end

        // toggle mask
        step(1'b1, 1'b1, M_LOAD, 4'h0, 4'hA);
        step(1'b1, 1'b1, M_TOG, 4'h6, 4'h0);
        chk("tog_q",  32'(q),  32'hC);
        chk("tog_qb", 32'(qb), 32'h3);
        step(1'b1, 1'b1, M_TOG, 4'h0, 4'h0);
        chk("tog_hold_q", 32'(q), 32'hC);

        // reset mid-count discards a pending load
        step(1'b1, 1'b1, M_LOAD, 4'h0, 4'h6);
        step(1'b1, 1'b1, M_UP, 4'h0, 4'h0);
        chk("pre_rst_q", 32'(q), 32'h7);
        step(1'b0, 1'b1, M_LOAD, 4'h0, 4'hF);
        chk("mid_rst_q",  32'(q),  32'h0);
        chk("mid_rst_tc", 32'(tc), 32'h0);

        // saturation / wrap near all-ones
        step(1'b1, 1'b1, M_LOAD, 4'h0, 4'hE);
        step(1'b1, 1'b1, M_UP, 4'h0, 4'h0);
        chk("lim1_q",  32'(q),  32'hF);
        chk("lim1_tc", 32'(tc), 32'h0);
        step(1'b1, 1'b1, M_UP, 4'h0, 4'h0);
        chk("lim2_q",  32'(q),  SAT ? 32'hF : 32'h0);
        chk("lim2_tc", 32'(tc), 32'h1);
        step(1'b1, 1'b1, M_UP, 4'h0, 4'h0);
        chk("lim3_q",  32'(q),  SAT ? 32'hF : 32'h1);
        chk("lim3_tc", 32'(tc), SAT ? 32'h1 : 32'h0);

        // random traffic, checked by the per-cycle compare
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit bank of toggle cells with a shared mode select.
- Operates either as an independent toggle register (per-bit T mask) or as a synchronous up/down counter built from cascaded toggle enables, with parallel load.
- Used as a general divider/event-counter primitive in the FlipFlops library and above it.
- Registered q/qb, plus terminal-count and zero flags.

Parameters:
- WIDTH, 8, number of toggle cells / counter bits (>=2)
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  update enable; when low all state holds (load included)
- mode  input  2  00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD
- t  input  WIDTH  per-bit toggle mask, used only in TOGGLE mode
- d  input  WIDTH  parallel load value, used only in LOAD mode
- q  output  WIDTH  registered state
- qb  output  WIDTH  registered complement of q; always equals ~q
- tc  output  1  registered terminal-count pulse
- zero  output  1  registered flag, high when q == 0

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset: on a posedge with rst_n=0: q=RST_VAL, qb=~RST_VAL, tc=0, zero=(RST_VAL==0). Reset overrides en and mode. Reset asserted mid-count discards any pending update in that cycle.
- Priority at each posedge: rst_n low > en low (hold, tc forced 0) > mode action.
- TOGGLE: q[i] <= q[i] ^ t[i]. t=0 holds. tc=0.
- UP: bit i toggles when en and q[i-1:0] are all ones; bit 0 always toggles. Result equals q+1 mod 2^WIDTH.
- DOWN: bit i toggles when q[i-1:0] are all zeros. Result equals q-1 mod 2^WIDTH.
- LOAD: q <= d. tc=0.
- Wrap: UP from all-ones to 0, or DOWN from 0 to all-ones, sets tc=1 for exactly the one cycle after that edge. Otherwise tc=0.
- zero and qb are registered alongside q, so they are consistent with q in every cycle. There is no combinational input-to-output path.
- Latency: 1 clock from the sampled inputs to q, qb, tc and zero.
- Mode may change every cycle. No internal state other than q and the flags, so there is no history across mode changes.
- Toggle cascade is computed as a combinational prefix AND/NOR chain in the same cycle; there is no ripple clocking.

Optional Feature:
- Macro: TFF_COUNTER_SAT_EN
- Defined: UP at all-ones and DOWN at 0 hold q instead of wrapping. tc=1 in the cycle after any enabled UP/DOWN update attempted at that limit, and repeats each such cycle.
- Not defined: modular wrap as described in Behaviour.
- TOGGLE and LOAD are unaffected in both builds.

Decomposition:
- Shared package tff_pkg: mode enum (TFF_MODE_TOGGLE=2'b00, TFF_MODE_UP=2'b01, TFF_MODE_DOWN=2'b10, TFF_MODE_LOAD=2'b11).
- Natural sub-module: tff_bit, a single toggle cell with synchronous active-low reset, reset value, toggle enable and load, outputs q/qb.
- tff_counter instantiates WIDTH tff_bit and owns the cascade logic, the tc/zero flags and the saturation logic.

Test Plan (WIDTH=4, RST_VAL=0):
- Reset: hold rst_n=0 for 2 clocks with en=1, mode=UP -> q=0000, qb=1111, zero=1, tc=0. Releasing rst_n gives q=0001 after the next edge.
- UP wrap: en=1, mode=UP for 16 clocks from 0 -> q steps 1..15 then 0. tc=1 only in the cycle q returns to 0. zero=1 in that same cycle.
- DOWN wrap plus hold: load d=0001, then DOWN for 2 clocks -> q=0000, then 1111 with tc=1. Dropping en for 3 clocks -> q stays 1111 and tc=0.
- TOGGLE mask: q=1010, mode=TOGGLE, t=0110 -> q=1100, qb=0011. Then t=0000 -> q holds 1100.
- Mid-operation reset: counting UP at q=0111, assert rst_n=0 for one clock with mode=LOAD, d=1111 -> q=0000, load ignored, tc=0.
- TFF_COUNTER_SAT_EN build: load 1110, UP for 3 clocks -> q=1111, 1111, 1111. tc=1 in the cycles after the 2nd and 3rd edges. A non-saturating build gives 1111, 0000, 0001.
